// File: rtl/song_store_ctrl.sv
// rtl/song_store_ctrl.sv - per-user song slot store with note write, protected playback and pause/stop
module song_store_ctrl #(
  parameter int CLOCK_FREQUENCY = 100,
  parameter int NUM_USERS       = 3,
  parameter int SONGS_PER_USER  = 3,
  parameter int NOTES_PER_SONG  = 60,
  parameter int NOTE_WIDTH      = 8,
  localparam int UW = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1,
  localparam int SW = (SONGS_PER_USER > 1) ? $clog2(SONGS_PER_USER) : 1,
  localparam int NW = $clog2(NOTES_PER_SONG + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [UW-1:0]         requser,
  input  logic [UW-1:0]         user,
  input  logic [SW-1:0]         song,
  input  logic [NOTE_WIDTH-1:0] inote,
  input  logic [NW-1:0]         noteOffset,
  input  logic [1:0]            tempo,
  input  logic                  loop,
  input  logic                  writeNote,
  input  logic                  playSong,
  input  logic                  protectionChange,
  input  logic                  stopSong,
  input  logic                  pauseSong,
  output logic [NOTE_WIDTH-1:0] onote,
  output logic [NW-1:0]         currNote,
  output logic [NW-1:0]         songLength,
  output logic                  noteValid,
  output logic                  prohibited,
  output logic                  busy,
  output logic                  done
);

  localparam int SLOT  = NOTES_PER_SONG + 1;
  localparam int DEPTH = NUM_USERS * SONGS_PER_USER * SLOT;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int HALF  = CLOCK_FREQUENCY / 2;
  localparam int CW    = (HALF > 1) ? $clog2(HALF + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_NOTE, S_WR_HDR_RD, S_WR_HDR_WR, S_PLAY_HDR_RD, S_PLAY_CHECK,
    S_PLAY, S_PAUSED, S_PCHG_RD, S_PCHG_WR, S_PROHIBITED
  } state_t;

  state_t                state_q, state_d;
  logic [UW-1:0]         user_q, user_d, requser_q, requser_d;
  logic [SW-1:0]         song_q, song_d;
  logic [1:0]            tempo_q, tempo_d;
  logic                  loop_q, loop_d;
  logic [NOTE_WIDTH-1:0] note_q, note_d;
  logic [NW-1:0]         off_q, off_d;
  logic [NW-1:0]         curr_note_q, curr_note_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NW-1:0]         song_length_q, song_length_d;
  logic                  note_valid_q, note_valid_d;
  logic                  done_q, done_d;

  logic [NOTE_WIDTH-1:0] mem [DEPTH] = '{default: '0};
  logic [NOTE_WIDTH-1:0] ram_rdata, ram_wdata;
  logic [AW-1:0]         ram_addr, base;
  logic                  ram_we;

  logic [NW-1:0] hdr_len, off_plus1, new_len;
  logic          hdr_priv, slot_ok, off_ok, cnt_last, note_last;
  logic [CW-1:0] dur;

  function automatic logic [NOTE_WIDTH-1:0] hdr_word(input logic [NW-1:0] len, input logic priv);
    hdr_word         = '0;
    hdr_word[NW:1]   = len;
    hdr_word[0]      = priv;
  endfunction

  assign base      = AW'((int'(user_q) * SONGS_PER_USER + int'(song_q)) * SLOT);
  assign hdr_len   = ram_rdata[NW:1];
  assign hdr_priv  = ram_rdata[0];
  assign off_plus1 = off_q + NW'(1);
  assign new_len   = (off_plus1 > hdr_len) ? off_plus1 : hdr_len;
  assign slot_ok   = (int'(user) < NUM_USERS) && (int'(song) < SONGS_PER_USER);
  assign off_ok    = int'(noteOffset) < NOTES_PER_SONG;
  // Fast tempos may shift the half-second count to zero; a note always lasts a cycle.
  assign dur       = (CW'(HALF >> tempo_q) == '0) ? CW'(1) : CW'(HALF >> tempo_q);
  assign cnt_last  = (cnt_q == dur - CW'(1));
  assign note_last = (curr_note_q == song_length_q - NW'(1));

  always_ff @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      user_q        <= '0;
      requser_q     <= '0;
      song_q        <= '0;
      tempo_q       <= '0;
      loop_q        <= 1'b0;
      note_q        <= '0;
      off_q         <= '0;
      curr_note_q   <= '0;
      cnt_q         <= '0;
      song_length_q <= '0;
      note_valid_q  <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      user_q        <= user_d;
      requser_q     <= requser_d;
      song_q        <= song_d;
      tempo_q       <= tempo_d;
      loop_q        <= loop_d;
      note_q        <= note_d;
      off_q         <= off_d;
      curr_note_q   <= curr_note_d;
      cnt_q         <= cnt_d;
      song_length_q <= song_length_d;
      note_valid_q  <= note_valid_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    user_d        = user_q;
    requser_d     = requser_q;
    song_d        = song_q;
    tempo_d       = tempo_q;
    loop_d        = loop_q;
    note_d        = note_q;
    off_d         = off_q;
    curr_note_d   = curr_note_q;
    cnt_d         = cnt_q;
    song_length_d = song_length_q;
    note_valid_d  = 1'b0;
    done_d        = 1'b0;
    case (state_q)
      S_IDLE, S_PROHIBITED: begin
        if (writeNote || playSong || protectionChange) begin
          user_d    = user;
          requser_d = requser;
          song_d    = song;
          tempo_d   = tempo;
          loop_d    = loop;
          note_d    = inote;
          off_d     = noteOffset;
          if (writeNote)     state_d = (slot_ok && off_ok) ? S_WR_NOTE : S_PROHIBITED;
          else if (playSong) state_d = slot_ok ? S_PLAY_HDR_RD : S_PROHIBITED;
          else               state_d = slot_ok ? S_PCHG_RD : S_PROHIBITED;
        end
      end
      S_WR_NOTE:     state_d = S_WR_HDR_RD;
      S_WR_HDR_RD:   state_d = S_WR_HDR_WR;
      S_WR_HDR_WR: begin
        song_length_d = hdr_len;
        state_d       = S_IDLE;
      end
      S_PLAY_HDR_RD: state_d = S_PLAY_CHECK;
      S_PLAY_CHECK: begin
        song_length_d = hdr_len;
        curr_note_d   = '0;
        cnt_d         = '0;
        if (hdr_priv && (requser_q != user_q)) state_d = S_PROHIBITED;
        else if (hdr_len == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else state_d = S_PLAY;
      end
      S_PLAY: begin
        if (stopSong) begin
          state_d     = S_IDLE;
          curr_note_d = '0;
          cnt_d       = '0;
        end else if (pauseSong) begin
          state_d = S_PAUSED;
        end else if (cnt_last) begin
          cnt_d = '0;
          if (!note_last) curr_note_d = curr_note_q + NW'(1);
          else begin
            curr_note_d = '0;
            if (!loop_q) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        end else begin
          cnt_d        = cnt_q + CW'(1);
          note_valid_d = 1'b1;
        end
      end
      S_PAUSED: begin
        if (stopSong) begin
          state_d     = S_IDLE;
          curr_note_d = '0;
          cnt_d       = '0;
        end else if (pauseSong) state_d = S_PLAY;
      end
      S_PCHG_RD:     state_d = S_PCHG_WR;
      S_PCHG_WR: begin
        song_length_d = hdr_len;
        state_d       = S_IDLE;
      end
      default:       state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ram_addr  = base;
    ram_we    = 1'b0;
    ram_wdata = '0;
    case (state_q)
      S_WR_NOTE: begin
        ram_addr  = base + AW'(1) + AW'(off_q);
        ram_we    = 1'b1;
        ram_wdata = note_q;
      end
      S_WR_HDR_WR: begin
        ram_we    = 1'b1;
        ram_wdata = hdr_word(new_len, hdr_priv);
      end
      S_PCHG_WR: begin
        ram_we    = 1'b1;
        ram_wdata = hdr_word(hdr_len, note_q[0]);
      end
      S_PLAY, S_PAUSED: ram_addr = base + AW'(1) + AW'(curr_note_q);
      default: ;
    endcase
    // A reset arriving mid-operation must not let the pending write land.
    if (reset) ram_we = 1'b0;
  end

  assign onote      = ram_rdata;
  assign currNote   = curr_note_q;
  assign songLength = song_length_q;
  assign noteValid  = note_valid_q;
  assign done       = done_q;
  assign prohibited = (state_q == S_PROHIBITED);
  assign busy       = (state_q != S_IDLE) && (state_q != S_PROHIBITED);

endmodule

// File: tb/tb_song_store_ctrl.sv
// tb/tb_song_store_ctrl.sv - self-checking bench for song_store_ctrl with a slot-level behavioural model
module tb_song_store_ctrl;

  localparam int NU = 3, NS = 3, NN = 60, HALF = 50;
  localparam int UW = 2, SW = 2, NW = 6;

  logic          clk = 1'b0, reset = 1'b1;
  logic [UW-1:0] requser = '0, user = '0;
  logic [SW-1:0] song = '0;
  logic [7:0]    inote = '0;
  logic [NW-1:0] noteOffset = '0;
  logic [1:0]    tempo = '0;
  logic          loop = 1'b0;
  logic          writeNote = 1'b0, playSong = 1'b0, protectionChange = 1'b0;
  logic          stopSong = 1'b0, pauseSong = 1'b0;
  logic [7:0]    onote;
  logic [NW-1:0] currNote, songLength;
  logic          noteValid, prohibited, busy, done;

  song_store_ctrl dut (
    .clock(clk), .reset(reset), .requser(requser), .user(user), .song(song),
    .inote(inote), .noteOffset(noteOffset), .tempo(tempo), .loop(loop),
    .writeNote(writeNote), .playSong(playSong), .protectionChange(protectionChange),
    .stopSong(stopSong), .pauseSong(pauseSong), .onote(onote), .currNote(currNote),
    .songLength(songLength), .noteValid(noteValid), .prohibited(prohibited),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Slot-level model: song contents per slot, plus the phase of the current command.
  int m_len [NU][NS];
  bit m_priv[NU][NS];
  int m_note[NU][NS][NN];
  int ph = 0;  // 0 idle, 1 busy in a RAM sequence, 2 playing, 3 paused, 4 prohibited
  bit m_valid = 0, m_nv = 0, m_done = 0;
  int m_left, m_op, m_u, m_s, m_rq, m_off, m_nt, m_d, m_loop, m_plen, m_t, m_slen, m_cur;

  always @(negedge clk) begin
    if (m_valid) begin
      m_cur = (ph == 2 || ph == 3) ? (m_t / m_d) % m_plen : 0;
      chk("busy", int'(busy), int'(ph == 1 || ph == 2 || ph == 3));
      chk("prohibited", int'(prohibited), int'(ph == 4));
      chk("done", int'(done), int'(m_done));
      chk("noteValid", int'(noteValid), int'(ph == 2 && m_nv));
      chk("currNote", int'(currNote), m_cur);
      chk("songLength", int'(songLength), m_slen);
      if (ph == 2 && noteValid) chk("onote", int'(onote), m_note[m_u][m_s][m_cur]);
    end
    m_done = 0;
    if (reset) begin
      m_valid = 1; ph = 0; m_slen = 0; m_t = 0; m_nv = 0;
    end else if (m_valid) begin
      case (ph)
        0, 4: if (writeNote || playSong || protectionChange) begin
          m_u = int'(user); m_s = int'(song); m_rq = int'(requser);
          m_off = int'(noteOffset); m_nt = int'(inote); m_loop = int'(loop);
          m_d = HALF >> int'(tempo);
          if (m_d == 0) m_d = 1;
          m_op = writeNote ? 1 : (playSong ? 2 : 3);
          if (m_u >= NU || m_s >= NS || (m_op == 1 && m_off >= NN)) ph = 4;
          else begin
            ph = 1;
            m_left = (m_op == 1) ? 3 : 2;
            if (m_op == 1) m_note[m_u][m_s][m_off] = m_nt;
          end
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_slen = m_len[m_u][m_s];
            ph = 0;
            if (m_op == 1) begin
              if (m_off + 1 > m_len[m_u][m_s]) m_len[m_u][m_s] = m_off + 1;
            end else if (m_op == 3) m_priv[m_u][m_s] = m_nt[0];
            else if (m_priv[m_u][m_s] && m_rq != m_u) ph = 4;
            else if (m_len[m_u][m_s] == 0) m_done = 1;
            else begin ph = 2; m_plen = m_len[m_u][m_s]; m_t = 0; m_nv = 0; end
          end
        end
        2: if (stopSong) ph = 0;
           else if (pauseSong) ph = 3;
           else begin
             m_t++;
             if (m_t == m_plen * m_d) begin
               if (m_loop != 0) m_t = 0;
               else begin ph = 0; m_done = 1; end
             end
             m_nv = (m_t % m_d) != 0;
           end
        3: if (stopSong) ph = 0;
           else if (pauseSong) begin ph = 2; m_nv = 0; end
        default: ph = 0;
      endcase
    end
  end

  logic [7:0] seq_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input bit w, input bit p, input bit c, input int u, input int s,
                     input int rq, input int off, input int nt, input int tp, input int lp);
    user = UW'(u); song = SW'(s); requser = UW'(rq); noteOffset = NW'(off);
    inote = 8'(nt); tempo = 2'(tp); loop = lp[0];
    writeNote = w; playSong = p; protectionChange = c;
    tick();
    writeNote = 1'b0; playSong = 1'b0; protectionChange = 1'b0;
  endtask

  task automatic write(input int u, input int s, input int off, input int nt);
    cmd(1, 0, 0, u, s, 0, off, nt, 0, 0);
    repeat (3) tick();
  endtask

  task automatic run_to_done(inout int k);
    do begin
      tick();
      k++;
      if (noteValid && (seq_q.size() == 0 || seq_q[$] != onote)) seq_q.push_back(onote);
    end while (!done && k < 2000);
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic play_run(input int u, input int s, input int rq, input int tp, output int k);
    seq_q.delete();
    cmd(0, 1, 0, u, s, rq, 0, 0, tp, 0);
    k = 0;
    run_to_done(k);
  endtask

  function automatic int seq_at(input int i);
    return (seq_q.size() > i) ? int'(seq_q[i]) : -1;
  endfunction

  int k;

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_songLength", int'(songLength), 0);
    chk("rst_currNote", int'(currNote), 0);

    write(1, 2, 0, 'h11); write(1, 2, 1, 'h22); write(1, 2, 2, 'h33);
    play_run(1, 2, 1, 0, k);
    chk("play3_done_cycle", k, 152);
    chk("play3_seq_len", seq_q.size(), 3);
    chk("play3_n0", seq_at(0), 'h11);
    chk("play3_n1", seq_at(1), 'h22);
    chk("play3_n2", seq_at(2), 'h33);
    chk("play3_songLength", int'(songLength), 3);

    cmd(0, 1, 0, 1, 2, 1, 0, 0, 0, 0);
    repeat (78) tick();
    pauseSong = 1'b1; tick(); pauseSong = 1'b0;
    chk("pause_currNote", int'(currNote), 1);
    chk("pause_noteValid", int'(noteValid), 0);
    repeat (19) tick();
    pauseSong = 1'b1; tick(); pauseSong = 1'b0;
    k = 99;
    run_to_done(k);
    chk("pause_done_cycle", k, 173);

    write(0, 1, 0, 'h0A); write(0, 1, 1, 'h0B);
    cmd(0, 1, 0, 0, 1, 0, 0, 0, 3, 1);
    repeat (8) tick();
    chk("loop_note1", int'(currNote), 1);
    repeat (6) tick();
    chk("loop_wrap", int'(currNote), 0);
    repeat (20) tick();
    chk("loop_late", int'(currNote), 1);
    stopSong = 1'b1; tick(); stopSong = 1'b0;
    chk("stop_currNote", int'(currNote), 0);
    chk("stop_busy", int'(busy), 0);

    write(0, 0, 0, 'h44);
    cmd(0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    repeat (2) tick();
    cmd(0, 1, 0, 0, 0, 2, 0, 0, 0, 0);
    repeat (2) tick();
    chk("priv_prohibited", int'(prohibited), 1);
    repeat (5) tick();
    play_run(0, 0, 0, 2, k);
    chk("priv_owner_done", k, 14);
    chk("priv_owner_note", seq_at(0), 'h44);

    cmd(1, 0, 0, 2, 2, 0, 60, 'h99, 0, 0);
    chk("offset_prohibited", int'(prohibited), 1);
    play_run(2, 2, 0, 0, k);
    chk("empty_done_cycle", k, 2);
    chk("empty_no_notes", seq_q.size(), 0);

    cmd(0, 1, 0, 3, 0, 0, 0, 0, 0, 0);
    chk("bad_user_prohibited", int'(prohibited), 1);

    cmd(1, 1, 0, 2, 1, 0, 0, 'h77, 0, 0);
    repeat (3) tick();
    play_run(2, 1, 0, 3, k);
    chk("prio_done_cycle", k, 8);
    chk("prio_note", seq_at(0), 'h77);

    cmd(1, 0, 0, 2, 0, 0, 0, 'h5A, 0, 0);
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_songLength", int'(songLength), 0);
    chk("abort_done", int'(done), 0);
    write(2, 0, 1, 'h6B);
    play_run(2, 0, 0, 3, k);
    chk("abort_done_cycle", k, 14);
    chk("abort_n0", seq_at(0), 'h5A);
    chk("abort_n1", seq_at(1), 'h6B);
    chk("abort_songLength2", int'(songLength), 2);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
